// File: rtl/zuart_tx_arbiter_if.sv
// Requester-side byte streams and TX FIFO write port shared by the packet arbiter.
// The arbiter uses the slave view; the requesters and FIFO model use the master view.
interface zuart_tx_arbiter_if #(
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0]   iValid;
  logic [8*NUM_SRC-1:0] iData;
  logic [NUM_SRC-1:0]   iLast;
  logic [NUM_SRC-1:0]   oReady;
  logic                 oWrEn;
  logic [7:0]           oWrData;
  logic                 iFull;

  modport master (
    output iValid, iData, iLast, iFull,
    input  oReady, oWrEn, oWrData
  );

  modport slave (
    input  iValid, iData, iLast, iFull,
    output oReady, oWrEn, oWrData
  );
endinterface

// File: rtl/zuart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one UART TX FIFO write port, with an
// optional source-ID header byte per packet and a byte-count watchdog.
module zuart_tx_arbiter #(
  parameter int NUM_SRC = 3,
  parameter bit HDR_EN  = 1'b1,
  parameter int MAX_LEN = 64
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEn,
  zuart_tx_arbiter_if.slave   bus,
  output logic                oBusy,
  output logic [1:0]          oGrantId,
  output logic                oOverrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0] MAX_CNT   = 8'(MAX_LEN);
  localparam logic [1:0] PTR_RESET = 2'(NUM_SRC - 1);

  state_t     state_reg, state_next;
  logic [1:0] grant_reg, grant_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [7:0] count_reg, count_next;
  logic       overrun_reg, overrun_next;

  logic [7:0] src_data [NUM_SRC];
  logic       g_valid;
  logic       g_last;
  logic [7:0] g_data;
  logic       rr_found;
  logic [1:0] rr_win;
  logic [7:0] header;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_data[gi] = bus.iData[8*gi +: 8];
    end
  endgenerate

  // View of the currently granted source, selected without an out-of-range index.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = 8'h00;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_reg == 2'(k)) begin
        g_valid = bus.iValid[k];
        g_last  = bus.iLast[k];
        g_data  = src_data[k];
      end
    end
  end

  // First requester after the last granted one, wrapping at NUM_SRC.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_win   = ptr_reg;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      if (!rr_found && bus.iValid[idx]) begin
        rr_found = 1'b1;
        rr_win   = 2'(idx);
      end
    end
  end

  assign header = {4'hA, 2'b00, grant_reg};

  always_comb begin
    bus.oReady  = '0;
    bus.oWrEn   = 1'b0;
    bus.oWrData = 8'h00;
    case (state_reg)
      HDR: begin
        bus.oWrEn   = !bus.iFull;
        bus.oWrData = header;
      end
      DATA: begin
        for (int k = 0; k < NUM_SRC; k++) begin
          if (grant_reg == 2'(k)) begin
            bus.oReady[k] = !bus.iFull;
          end
        end
        bus.oWrEn   = g_valid && !bus.iFull;
        bus.oWrData = g_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
    count_next   = count_reg;
    overrun_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (iEn && rr_found) begin
          grant_next = rr_win;
          ptr_next   = rr_win;
          count_next = 8'h00;
          state_next = HDR_EN ? HDR : DATA;
        end
      end
      HDR: begin
        if (bus.oWrEn) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bus.oWrEn) begin
          count_next = count_reg + 8'd1;
          if (g_last) begin
            state_next = IDLE;
          end else if (count_reg + 8'd1 == MAX_CNT) begin
            // Packet never signalled last: release the port, the rest becomes a new packet.
            state_next   = IDLE;
            overrun_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_reg   <= IDLE;
      grant_reg   <= 2'd0;
      ptr_reg     <= PTR_RESET;
      count_reg   <= 8'h00;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
    end
  end

  assign oBusy    = (state_reg != IDLE);
  assign oGrantId = grant_reg;
  assign oOverrun = overrun_reg;

endmodule

// File: doc/zuart_tx_arbiter.md
# zuart_tx_arbiter

Packet-level round-robin arbiter that shares one UART TX FIFO write port among NUM_SRC byte-stream requesters. It sits in front of the TX FIFO write interface of the UART transmit path. It locks the grant to one source until that source's packet ends, optionally prefixes each packet with a source-ID header byte, and stalls on FIFO full. A byte-count watchdog force-releases a packet that never signals last.

## Interface
- NUM_SRC, 3: number of requesters, legal 2..4
- HDR_EN, 1: 1 = emit header byte {4'hA, 2'b00, id[1:0]} before each packet; 0 = no header
- MAX_LEN, 64: maximum data bytes per packet, legal 1..255
- iClk  in  1  system clock
- iRstN  in  1  reset, asynchronous, active-low
- iEn  in  1  1 = new grants allowed; 0 = current packet finishes, then no new grant
- iValid  in  NUM_SRC  per-source byte valid
- iData  in  8*NUM_SRC  per-source byte; source k occupies bits [8k+7:8k]
- iLast  in  NUM_SRC  per-source last-byte-of-packet flag, qualified by iValid
- oReady  out  NUM_SRC  per-source byte accepted this cycle when paired with iValid
- oWrEn  out  1  FIFO write strobe, one byte per high cycle
- oWrData  out  8  FIFO write data
- iFull  in  1  FIFO full; no write while high
- oBusy  out  1  high in HDR or DATA state
- oGrantId  out  2  currently or last granted source index
- oOverrun  out  1  one-cycle pulse when the watchdog force-ends a packet

## Operation
- States: IDLE, HDR, DATA. State, grant id, round-robin pointer (last granted id) and byte counter (8 bit) are registered. oReady, oWrEn and oWrData are combinational from the registered state plus iValid, iData and iFull.
- In IDLE with iEn=1 and any iValid set:
  - Grant the first valid source searching from (last+1) mod NUM_SRC upward with wrap.
  - Load the grant and pointer with that source, clear the counter.
  - Go to HDR if HDR_EN=1, else DATA.
- HDR: oWrEn = !iFull and oWrData = header. When oWrEn=1, go to DATA. All oReady are 0 in this state.
- DATA: oReady[g] = !iFull; all other oReady bits are 0. oWrEn = iValid[g] && !iFull and oWrData = iData[g].
- Accept: an accepted byte (oWrEn=1) increments the counter.
- Packet end: on an accepted byte with iLast[g]=1, go to IDLE.
- Watchdog: if an accepted byte brings the counter to MAX_LEN with iLast=0, go to IDLE and pulse oOverrun for one cycle (the cycle after acceptance). The source's following bytes start a new packet.
- If the granted source drops iValid mid-packet, the grant is held indefinitely. The counter counts accepted bytes only.
- iEn going low never aborts HDR or DATA; it only blocks leaving IDLE.
- iFull=1 freezes all progress: no write, no state change, no count.
- Requests from non-granted sources are held off (oReady=0) and never lost.

## Timing
- Reset values: state IDLE; oWrEn=0, oReady=0, oBusy=0, oOverrun=0, oGrantId=0; pointer=NUM_SRC-1 so source 0 wins first; counter=0.
- With HDR_EN=1 and iFull=0:
  - iValid seen in IDLE at cycle n gives the header write at n+1.
  - The first data byte is written at n+2 if valid.
  - Then one byte per cycle.
- With HDR_EN=0, the first data byte is written at n+1.
- After the last byte at cycle m, the state is IDLE at m+1 and the next packet's header is at m+2. There is exactly one idle cycle between packets.
- Simultaneous requests resolve in the same IDLE cycle by round-robin order only.
- Asynchronous reset mid-packet: outputs go to their reset values immediately. The partial packet is abandoned in the FIFO; no repair is done.

## Test plan
- Single source 1, 3-byte packet 11,22,33 with last on 33, HDR_EN=1 -> FIFO receives A1,11,22,33 on consecutive cycles; oBusy high for 4 cycles.
- Sources 0, 1 and 2 all valid continuously with 2-byte packets -> packet order 0,1,2,0; one idle cycle between packets; no interleaving inside a packet.
- iFull high for 5 cycles mid-packet -> oWrEn=0 and oReady=0 for those cycles; no byte lost or duplicated; the sequence resumes exactly.
- MAX_LEN=4, source 2 sends 6 bytes with no last -> A2 + 4 bytes, oOverrun pulse, then A2 + 2 bytes as a new packet (or another source's packet first if one is pending under round-robin).
- iEn dropped during a packet from source 0 -> packet completes, then no new grant while iEn=0 even with iValid set; resumes with source 1 after iEn=1.
- iRstN asserted mid-DATA -> oWrEn=0 immediately; after release the first grant goes to source 0.
